thumb_multi_xfer_seq: RTL and testbench
=======================================

Name: thumb_multi_xfer_seq

Overview:
- Multi-cycle sequencer for Thumb LDM, STM, PUSH and POP.
- Decode issues one command with a register list. The block steps the list lowest register first, one word-memory transfer per register, using a req/ack handshake.
- At the end it issues the base-register writeback and flags a PC load for POP {..,PC}.
- Sits between the Thumb decoder/register-file read stage and the data-memory port. The core stalls issue while busy=1.

Parameters:
- ADDR_W, 32: address and data width.
- SP_IDX, 13: register index used as stack pointer.
- LR_IDX, 14: register index for PUSH list bit 8.
- PC_IDX, 15: register index for POP list bit 8.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command valid; accepted only when start_ready=1.
- start_ready  output  1  high in IDLE.
- op  input  2  00 LDM, 01 STM, 10 PUSH, 11 POP.
- reg_list  input  9  bits[7:0] = R0..R7; bit 8 = LR (PUSH) or PC (POP); bit 8 is ignored for LDM/STM.
- base_reg  input  3  Rn for LDM/STM; ignored for PUSH/POP (SP_IDX is used).
- base_val  input  ADDR_W  current value of Rn or SP.
- busy  output  1  high from acceptance until the DONE cycle inclusive.
- mem_req  output  1  transfer request.
- mem_we  output  1  1 = store (STM/PUSH), 0 = load.
- mem_addr  output  ADDR_W  word address of the current transfer.
- mem_reg  output  4  register being stored or loaded.
- mem_ack  input  1  transfer completes in a cycle where mem_req && mem_ack.
- wb_en  output  1  base writeback strobe (single cycle).
- wb_reg  output  4  writeback register index.
- wb_val  output  ADDR_W  writeback value.
- pc_load  output  1  pulses with done when POP included PC.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except start_ready=1; internal list, address and count cleared. Reset mid-sequence abandons it with no writeback.
- States: IDLE, XFER, DONE.
- IDLE: on start=1, latch op, the effective list (bit 8 masked for LDM/STM) and base_reg. N = popcount(effective list).
- Start address and writeback value, computed at acceptance:
  - LDM/STM: addr = base_val; wb = base_val + 4N.
  - POP: addr = base_val; wb = base_val + 4N.
  - PUSH: addr = base_val - 4N; wb = base_val - 4N.
  - Arithmetic is modulo 2^ADDR_W; wrap is silent.
- Transition out of IDLE: if N=0 go to DONE (no transfers, no writeback); otherwise go to XFER. The first mem_req is asserted the cycle after acceptance.
- XFER:
  - mem_req=1; mem_addr, mem_reg and mem_we are held stable until ack.
  - On ack: clear the lowest set bit and add 4 to the address. The next request follows in the next cycle (back-to-back, no bubble).
  - On ack of the last register, go to DONE.
  - mem_ack while mem_req=0 is ignored.
- DONE (one cycle): done=1, busy=1, then IDLE.
  - wb_en=1 for STM, PUSH and POP always.
  - wb_en=1 for LDM only when base_reg is not in the list.
  - wb_reg = SP_IDX for PUSH/POP, base_reg otherwise.
  - pc_load=1 iff op=POP and bit 8 was set.
- Register order: ascending index, so the lowest register goes to the lowest address. Bit 8 maps to LR_IDX for PUSH and PC_IDX for POP, and is always transferred last.
- start asserted while busy is not accepted. It is not queued; the issuer must hold it.
- Throughput: 2 + N cycles minimum from acceptance to return to IDLE.

Optional Feature:
- Macro: MULTI_XFER_ABORT_EN.
- When defined:
  - Adds input mem_abort (1) and output abort (1).
  - mem_abort sampled with mem_ack in XFER ends the sequence: go to DONE with done=1, abort=1, wb_en=0, pc_load=0. Loads already completed remain written.
  - A misaligned start address (bits[1:0]!=0) aborts at acceptance with zero transfers.
- When undefined: no extra ports; address bits[1:0] are passed through unchecked.

Test Plan:
- PUSH {R0,R2,LR}, SP=0x1000, ack every cycle -> stores R0@0xFF4, R2@0xFF8, R14@0xFFC; wb SP=0xFF4; done at cycle 5 after start.
- POP {R1,PC}, SP=0x0FF8, ack delayed 3 cycles each -> loads R1@0xFF8, R15@0xFFC with addr/reg stable across stalls; wb SP=0x1000; pc_load=1 with done.
- LDM R3!,{R3,R4}, R3=0x200 -> loads @0x200, 0x204; wb_en=0. STM R3!,{R3,R4} -> wb_en=1, wb_val=0x208.
- Empty list LDM -> no mem_req; done next cycle; wb_en=0. Also: start asserted while busy is ignored.
- rst_n low during the 2nd transfer of a 4-register STM -> outputs 0 immediately; no wb; start_ready=1 after release.
- MULTI_XFER_ABORT_EN: abort on the 2nd ack of STM {R0-R3} -> abort=1, done=1, wb_en=0; base 0x102 -> immediate abort with no mem_req.

Source files
------------

// File: rtl/thumb_multi_xfer_seq.sv
// Thumb LDM/STM/PUSH/POP sequencer: walks the register list lowest-first with one word transfer per register, then issues base writeback.
// Optional abort support is enabled by defining MULTI_XFER_ABORT_EN.
module thumb_multi_xfer_seq #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SP_IDX = 13,
  parameter int unsigned LR_IDX = 14,
  parameter int unsigned PC_IDX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              start_ready,
  input  logic [1:0]        op,
  input  logic [8:0]        reg_list,
  input  logic [2:0]        base_reg,
  input  logic [ADDR_W-1:0] base_val,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_reg,
  input  logic              mem_ack,
  output logic              wb_en,
  output logic [3:0]        wb_reg,
  output logic [ADDR_W-1:0] wb_val,
  output logic              pc_load,
`ifdef MULTI_XFER_ABORT_EN
  input  logic              mem_abort,
  output logic              abort,
`endif
  output logic              done
);

  localparam int unsigned LIST_W = 9;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned REG_W  = 4;

  localparam logic [1:0] OP_LDM  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [LIST_W-1:0]   list_q, list_d;
  logic [2:0]          base_q, base_d;
  logic [ADDR_W-1:0]   wbv_q, wbv_d;
  logic                base_in_q, base_in_d;
  logic                pc_q, pc_d;

  logic                start_ready_d, busy_d, mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d, wb_val_d;
  logic [REG_W-1:0]    mem_reg_d, wb_reg_d;
  logic                wb_en_d, pc_load_d, done_d;
`ifdef MULTI_XFER_ABORT_EN
  logic                abort_d;
`endif

  logic [LIST_W-1:0]   eff_list, rest_list;
  logic [CNT_W-1:0]    n_cnt;
  logic [ADDR_W-1:0]   four_n;

  // Architectural register for the lowest set list bit; bit 8 is LR or PC depending on op.
  function automatic logic [REG_W-1:0] reg_of(input logic [LIST_W-1:0] l, input logic [1:0] o);
    reg_of = '0;
    for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
      if (l[i]) begin
        if (i == int'(LIST_W) - 1) reg_of = (o == OP_PUSH) ? REG_W'(LR_IDX) : REG_W'(PC_IDX);
        else                       reg_of = REG_W'(i);
      end
    end
  endfunction

  always_comb begin
    eff_list = (op[1]) ? reg_list : {1'b0, reg_list[7:0]};
    n_cnt    = '0;
    for (int i = 0; i < int'(LIST_W); i++) n_cnt = n_cnt + CNT_W'(eff_list[i]);
    four_n    = ADDR_W'(n_cnt) << 2;
    rest_list = list_q & (list_q - LIST_W'(1));
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    list_d        = list_q;
    base_d        = base_q;
    wbv_d         = wbv_q;
    base_in_d     = base_in_q;
    pc_d          = pc_q;
    start_ready_d = 1'b0;
    busy_d        = 1'b0;
    mem_req_d     = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = '0;
    mem_reg_d     = '0;
    wb_en_d       = 1'b0;
    wb_reg_d      = '0;
    wb_val_d      = '0;
    pc_load_d     = 1'b0;
    done_d        = 1'b0;
`ifdef MULTI_XFER_ABORT_EN
    abort_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        start_ready_d = 1'b1;
        if (start) begin
          start_ready_d = 1'b0;
          busy_d        = 1'b1;
          op_d          = op;
          list_d        = eff_list;
          base_d        = base_reg;
          base_in_d     = reg_list[base_reg];
          pc_d          = eff_list[8];
          wbv_d         = (op == OP_PUSH) ? base_val - four_n : base_val + four_n;
          if (n_cnt == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = XFER;
            mem_req_d  = 1'b1;
            mem_we_d   = op[1] ^ op[0];
            mem_addr_d = (op == OP_PUSH) ? base_val - four_n : base_val;
            mem_reg_d  = reg_of(eff_list, op);
          end
`ifdef MULTI_XFER_ABORT_EN
          if (mem_addr_d[1:0] != 2'b00) begin
            state_d    = DONE;
            done_d     = 1'b1;
            abort_d    = 1'b1;
            mem_req_d  = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = '0;
            mem_reg_d  = '0;
          end
`endif
        end
      end
      XFER: begin
        busy_d     = 1'b1;
        mem_req_d  = 1'b1;
        mem_we_d   = mem_we;
        mem_addr_d = mem_addr;
        mem_reg_d  = mem_reg;
        if (mem_ack) begin
          list_d = rest_list;
          if (rest_list == '0) begin
            state_d    = DONE;
            mem_req_d  = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = '0;
            mem_reg_d  = '0;
            done_d     = 1'b1;
            wb_en_d    = (op_q != OP_LDM) || !base_in_q;
            wb_reg_d   = op_q[1] ? REG_W'(SP_IDX) : {1'b0, base_q};
            wb_val_d   = wbv_q;
            pc_load_d  = (op_q == OP_POP) && pc_q;
          end else begin
            mem_addr_d = mem_addr + ADDR_W'(4);
            mem_reg_d  = reg_of(rest_list, op_q);
          end
`ifdef MULTI_XFER_ABORT_EN
          if (mem_abort) begin
            state_d    = DONE;
            list_d     = '0;
            mem_req_d  = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = '0;
            mem_reg_d  = '0;
            done_d     = 1'b1;
            abort_d    = 1'b1;
            wb_en_d    = 1'b0;
            wb_reg_d   = '0;
            wb_val_d   = '0;
            pc_load_d  = 1'b0;
          end
`endif
        end
      end
      DONE: begin
        state_d       = IDLE;
        start_ready_d = 1'b1;
        list_d        = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      list_q      <= '0;
      base_q      <= '0;
      wbv_q       <= '0;
      base_in_q   <= 1'b0;
      pc_q        <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_reg     <= '0;
      wb_en       <= 1'b0;
      wb_reg      <= '0;
      wb_val      <= '0;
      pc_load     <= 1'b0;
      done        <= 1'b0;
`ifdef MULTI_XFER_ABORT_EN
      abort       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      list_q      <= list_d;
      base_q      <= base_d;
      wbv_q       <= wbv_d;
      base_in_q   <= base_in_d;
      pc_q        <= pc_d;
      start_ready <= start_ready_d;
      busy        <= busy_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_reg     <= mem_reg_d;
      wb_en       <= wb_en_d;
      wb_reg      <= wb_reg_d;
      wb_val      <= wb_val_d;
      pc_load     <= pc_load_d;
      done        <= done_d;
`ifdef MULTI_XFER_ABORT_EN
      abort       <= abort_d;
`endif
    end
  end

endmodule

// File: tb/tb_thumb_multi_xfer_seq.sv
// Directed bench for thumb_multi_xfer_seq; abort cases run when MULTI_XFER_ABORT_EN is defined.
module tb_thumb_multi_xfer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start_ready;
  logic [1:0]  op;
  logic [8:0]  reg_list;
  logic [2:0]  base_reg;
  logic [31:0] base_val;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_reg;
  logic        mem_ack;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_val;
  logic        pc_load;
  logic        done;
`ifdef MULTI_XFER_ABORT_EN
  logic        mem_abort;
  logic        abort;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  thumb_multi_xfer_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .op(op), .reg_list(reg_list), .base_reg(base_reg), .base_val(base_val),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_reg(mem_reg), .mem_ack(mem_ack), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_val(wb_val), .pc_load(pc_load),
`ifdef MULTI_XFER_ABORT_EN
    .mem_abort(mem_abort), .abort(abort),
`endif
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a command for one cycle; returns just after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [8:0] l, input logic [2:0] b, input logic [31:0] v);
    @(negedge clk);
    chk("start_ready_idle", 32'(start_ready), 1);
    op = o; reg_list = l; base_reg = b; base_val = v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // One transfer: check the request holds for dly stall cycles, then ack it.
  task automatic xfer(input logic [31:0] addr, input logic [3:0] rg, input logic we, input int dly);
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      chk("mem_req", 32'(mem_req), 1);
      chk("mem_addr", mem_addr, addr);
      chk("mem_reg", 32'(mem_reg), 32'(rg));
      chk("mem_we", 32'(mem_we), 32'(we));
      chk("busy_xfer", 32'(busy), 1);
      mem_ack = (k == dly);
    end
    @(posedge clk);
    #1 mem_ack = 1'b0;
  endtask

  // DONE cycle followed by return to IDLE.
  task automatic finish_chk(input logic en, input logic [3:0] rg, input logic [31:0] val, input logic pc);
    @(negedge clk);
    chk("done", 32'(done), 1);
    chk("busy_done", 32'(busy), 1);
    chk("req_in_done", 32'(mem_req), 0);
    chk("wb_en", 32'(wb_en), 32'(en));
    if (en) begin
      chk("wb_reg", 32'(wb_reg), 32'(rg));
      chk("wb_val", wb_val, val);
    end
    chk("pc_load", 32'(pc_load), 32'(pc));
    @(negedge clk);
    chk("done_clear", 32'(done), 0);
    chk("wb_en_clear", 32'(wb_en), 0);
    chk("busy_clear", 32'(busy), 0);
    chk("start_ready_back", 32'(start_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; reg_list = '0; base_reg = '0; base_val = '0; mem_ack = 1'b0;
`ifdef MULTI_XFER_ABORT_EN
    mem_abort = 1'b0;
`endif
    #12;
    chk("rst_start_ready", 32'(start_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wb_en", 32'(wb_en), 0);
    @(negedge clk) rst_n = 1'b1;

    // PUSH {R0,R2,LR}, SP=0x1000
    issue(2'b10, 9'h105, 3'd0, 32'h1000);
    xfer(32'hFF4, 4'd0, 1'b1, 0);
    xfer(32'hFF8, 4'd2, 1'b1, 0);
    xfer(32'hFFC, 4'd14, 1'b1, 0);
    finish_chk(1'b1, 4'd13, 32'hFF4, 1'b0);

    // POP {R1,PC}, SP=0xFF8, 3-cycle ack delay
    issue(2'b11, 9'h102, 3'd0, 32'hFF8);
    xfer(32'hFF8, 4'd1, 1'b0, 3);
    xfer(32'hFFC, 4'd15, 1'b0, 3);
    finish_chk(1'b1, 4'd13, 32'h1000, 1'b1);

    // LDM R3!,{R3,R4}: base in list, no writeback
    issue(2'b00, 9'h018, 3'd3, 32'h200);
    xfer(32'h200, 4'd3, 1'b0, 0);
    xfer(32'h204, 4'd4, 1'b0, 0);
    finish_chk(1'b0, 4'd3, 32'h0, 1'b0);

    // STM R3!,{R3,R4}
    issue(2'b01, 9'h018, 3'd3, 32'h200);
    xfer(32'h200, 4'd3, 1'b1, 0);
    xfer(32'h204, 4'd4, 1'b1, 0);
    finish_chk(1'b1, 4'd3, 32'h208, 1'b0);

    // LDM R0!,{R1} with bit 8 set: bit 8 must be masked
    issue(2'b00, 9'h102, 3'd0, 32'h300);
    xfer(32'h300, 4'd1, 1'b0, 0);
    finish_chk(1'b1, 4'd0, 32'h304, 1'b0);

    // PUSH {R0} at SP=0: silent wrap
    issue(2'b10, 9'h001, 3'd0, 32'h0);
    xfer(32'hFFFF_FFFC, 4'd0, 1'b1, 0);
    finish_chk(1'b1, 4'd13, 32'hFFFF_FFFC, 1'b0);

    // Empty LDM; a start during DONE must be ignored
    issue(2'b00, 9'h000, 3'd1, 32'h500);
    @(negedge clk);
    chk("empty_req", 32'(mem_req), 0);
    chk("empty_done", 32'(done), 1);
    chk("empty_wb_en", 32'(wb_en), 0);
    chk("empty_start_ready", 32'(start_ready), 0);
    op = 2'b01; reg_list = 9'h001; base_val = 32'h600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored", 32'(busy), 0);
    chk("busy_start_noreq", 32'(mem_req), 0);
    chk("empty_idle", 32'(start_ready), 1);
    @(negedge clk);
    chk("busy_start_noreq2", 32'(mem_req), 0);

    // Reset during 2nd transfer of STM {R0-R3}
    issue(2'b01, 9'h00F, 3'd0, 32'h400);
    xfer(32'h400, 4'd0, 1'b1, 0);
    @(negedge clk);
    chk("pre_rst_addr", mem_addr, 32'h404);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_start_ready", 32'(start_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postrst_wb_en", 32'(wb_en), 0);
      chk("postrst_done", 32'(done), 0);
      chk("postrst_start_ready", 32'(start_ready), 1);
    end

`ifdef MULTI_XFER_ABORT_EN
    // Abort on 2nd ack of STM {R0-R3}
    issue(2'b01, 9'h00F, 3'd0, 32'h100);
    xfer(32'h100, 4'd0, 1'b1, 0);
    @(negedge clk);
    chk("ab_addr", mem_addr, 32'h104);
    mem_ack = 1'b1; mem_abort = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0; mem_abort = 1'b0;
    @(negedge clk);
    chk("ab_done", 32'(done), 1);
    chk("ab_abort", 32'(abort), 1);
    chk("ab_wb_en", 32'(wb_en), 0);
    chk("ab_req", 32'(mem_req), 0);
    @(negedge clk);
    chk("ab_idle", 32'(start_ready), 1);
    // Misaligned base aborts at acceptance
    issue(2'b01, 9'h00F, 3'd0, 32'h102);
    @(negedge clk);
    chk("mis_req", 32'(mem_req), 0);
    chk("mis_done", 32'(done), 1);
    chk("mis_abort", 32'(abort), 1);
    chk("mis_wb_en", 32'(wb_en), 0);
    @(negedge clk);
    chk("mis_idle", 32'(start_ready), 1);
`else
    // Misaligned base passes through unchecked
    issue(2'b00, 9'h001, 3'd2, 32'h102);
    xfer(32'h102, 4'd0, 1'b0, 0);
    finish_chk(1'b1, 4'd2, 32'h106, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
